// File: rtl/sha256_pkg.sv
// Shared widths and FSM state encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned BLOCK_W       = 512;
  localparam int unsigned LEN_W         = 64;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned NUM_BYTES     = BLOCK_W / BYTE_W;
  localparam int unsigned N_W           = 6;
  localparam int unsigned LAST_LEN_BYTE = 55;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    EXTRA = 2'd2
  } state_e;

endpackage

// File: rtl/sha256_padder_if.sv
// Byte-stream input and 512-bit block output handshakes of the padder.
interface sha256_padder_if;
  import sha256_pkg::*;

  logic               in_valid;
  logic [BYTE_W-1:0]  in_data;
  logic               in_end;
  logic               in_ready;
  logic               block_valid;
  logic [BLOCK_W-1:0] block_data;
  logic               block_last;
  logic               block_ready;

  modport master (
    output in_valid, in_data, in_end, block_ready,
    input  in_ready, block_valid, block_data, block_last
  );

  modport slave (
    input  in_valid, in_data, in_end, block_ready,
    output in_ready, block_valid, block_data, block_last
  );

endinterface

// File: rtl/sha256_padder.sv
// SHA-256 padder: packs message bytes into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit bit length, spilling to an extra block when needed.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  sha256_padder_if.slave  bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [BLOCK_W-1:0] r_block;
  logic [BLOCK_W-1:0] w_block_nxt;
  logic [N_W-1:0]     r_n;
  logic [N_W-1:0]     w_n_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_last;
  logic               w_last_nxt;
  logic               r_extra;
  logic               w_extra_nxt;
  logic               r_in_ready;
  logic               w_in_ready_nxt;
  logic               w_in_fire;
  logic               w_blk_fire;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_blk_fire = r_valid & bus.block_ready;

  assign bus.in_ready    = r_in_ready;
  assign bus.block_valid = r_valid;
  assign bus.block_data  = r_block;
  assign bus.block_last  = r_last;

  // State and datapath registers; the output block doubles as the fill buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FILL;
      r_block    <= '0;
      r_n        <= '0;
      r_len      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_extra    <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_block    <= w_block_nxt;
      r_n        <= w_n_nxt;
      r_len      <= w_len_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_extra    <= w_extra_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    w_state_nxt = r_state;
    w_block_nxt = r_block;
    w_n_nxt     = r_n;
    w_len_nxt   = r_len;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_extra_nxt = r_extra;

    case (r_state)
      FILL: begin
        if (w_in_fire) begin
          if (!bus.in_end) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
              if (N_W'(i) == r_n) begin
                w_block_nxt[BLOCK_W-1-BYTE_W*i -: BYTE_W] = bus.in_data;
              end
            end
            w_len_nxt = r_len + LEN_W'(BYTE_W);
            w_n_nxt   = r_n + N_W'(1);
            if (r_n == N_W'(NUM_BYTES - 1)) begin
              w_state_nxt = EMIT;
              w_valid_nxt = 1'b1;
              w_last_nxt  = 1'b0;
              w_extra_nxt = 1'b0;
            end
          end else begin
            // Pad marker at byte n, everything after it cleared of stale data.
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
              if (N_W'(i) == r_n) begin
                w_block_nxt[BLOCK_W-1-BYTE_W*i -: BYTE_W] = 8'h80;
              end else if (N_W'(i) > r_n) begin
                w_block_nxt[BLOCK_W-1-BYTE_W*i -: BYTE_W] = '0;
              end
            end
            if (r_n <= N_W'(LAST_LEN_BYTE)) begin
              w_block_nxt[LEN_W-1:0] = r_len;
              w_last_nxt             = 1'b1;
              w_extra_nxt            = 1'b0;
            end else begin
              w_last_nxt  = 1'b0;
              w_extra_nxt = 1'b1;
            end
            w_valid_nxt = 1'b1;
            w_state_nxt = EMIT;
          end
        end
      end

      EMIT: begin
        if (w_blk_fire) begin
          w_n_nxt = '0;
          if (r_extra) begin
            w_block_nxt = {(BLOCK_W - LEN_W)'(0), r_len};
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b1;
            w_extra_nxt = 1'b0;
            w_state_nxt = EXTRA;
          end else begin
            if (r_last) begin
              w_len_nxt = '0;
            end
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = FILL;
          end
        end
      end

      EXTRA: begin
        if (w_blk_fire) begin
          w_n_nxt     = '0;
          w_len_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_state_nxt = FILL;
        end
      end

      default: begin
        w_state_nxt = FILL;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_extra_nxt = 1'b0;
        w_n_nxt     = '0;
        w_len_nxt   = '0;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt == FILL);
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known messages, boundary lengths,
// output back-pressure and asynchronous reset during a pending block.
module tb_sha256_padder;
  import sha256_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  sha256_padder_if bus ();

  sha256_padder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got,
                       input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_in_ready(input string tag);
    int cnt = 0;
    while (!bus.in_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!bus.in_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_in_ready("byte");
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_end   = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_end();
    wait_in_ready("end");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_end   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b0;
  endtask

  task automatic get_block(input string tag, input logic [BLOCK_W-1:0] exp_data,
                           input logic exp_last);
    int cnt = 0;
    while (!bus.block_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!bus.block_valid) begin
      check({tag, "_valid_timeout"}, 0, 1);
    end else begin
      check({tag, "_data"}, bus.block_data, exp_data);
      check({tag, "_last"}, BLOCK_W'(bus.block_last), BLOCK_W'(exp_last));
      bus.block_ready = 1'b1;
      @(posedge clk); #1;
      bus.block_ready = 1'b0;
    end
  endtask

  logic [BLOCK_W-1:0] exp_abc;

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.in_end      = 1'b0;
    bus.block_ready = 1'b0;
    exp_abc         = {32'h61626380, 416'h0, 64'h18};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_valid", BLOCK_W'(bus.block_valid), 0);
    check("rst_last",  BLOCK_W'(bus.block_last), 0);
    check("rst_ready", BLOCK_W'(bus.in_ready), 1);
    check("rst_data",  bus.block_data, '0);

    // "abc"
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63); send_end();
    check("abc_latency", BLOCK_W'(bus.block_valid), 1);
    get_block("abc", exp_abc, 1'b1);
    check("abc_ready_after", BLOCK_W'(bus.in_ready), 1);

    // empty message
    send_end();
    get_block("empty", {8'h80, 440'h0, 64'h0}, 1'b1);

    // 55 bytes: length still fits in the same block
    for (int i = 0; i < 55; i++) send_byte(8'h00);
    send_end();
    get_block("len55", {440'h0, 8'h80, 64'h1B8}, 1'b1);

    // 56 bytes: length spills to an extra block
    for (int i = 0; i < 56; i++) send_byte(8'h00);
    send_end();
    get_block("len56_b1", {448'h0, 8'h80, 56'h0}, 1'b0);
    get_block("len56_b2", {448'h0, 64'h1C0}, 1'b1);

    // 64 bytes of 'A'
    for (int i = 0; i < 64; i++) send_byte(8'h41);
    get_block("len64_b1", {64{8'h41}}, 1'b0);
    send_end();
    get_block("len64_b2", {8'h80, 440'h0, 64'h200}, 1'b1);

    // back-pressure: block held, stray input beats ignored
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63); send_end();
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.in_end   = (i % 3) == 2;
      check("stall_data",  bus.block_data, exp_abc);
      check("stall_valid", BLOCK_W'(bus.block_valid), 1);
      check("stall_ready", BLOCK_W'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_end   = 1'b0;
    get_block("stall", exp_abc, 1'b1);
    check("stall_ready_after", BLOCK_W'(bus.in_ready), 1);
    check("stall_valid_after", BLOCK_W'(bus.block_valid), 0);
    send_byte(8'h61); send_byte(8'h62); send_end();
    get_block("ab", {24'h616280, 424'h0, 64'h10}, 1'b1);

    // reset while a block is pending
    send_byte(8'h78); send_byte(8'h79); send_byte(8'h7A); send_end();
    check("pre_rst_valid", BLOCK_W'(bus.block_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", BLOCK_W'(bus.block_valid), 0);
    check("async_rst_data",  bus.block_data, '0);
    check("async_rst_last",  BLOCK_W'(bus.block_last), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_ready", BLOCK_W'(bus.in_ready), 1);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63); send_end();
    get_block("abc_after_rst", exp_abc, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
